// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   This is a multi-cycle unsigned adder that computes {cout,sum} = a + b + cin.
//   Each clock it adds BITS_PER_CYCLE bits, starting from the LSB, through a
//   single carry-chained slice. A full WIDTH-bit add takes
//   N = WIDTH/BITS_PER_CYCLE cycles. The result is bit-identical to a
//   WIDTH-bit ripple adder.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request; sampled only while busy==0
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while an operation is in progress
//   done   out  1      one-cycle pulse when sum/cout have just been updated
//   sum    out  WIDTH  registered result; held until the next completion
//   cout   out  1      registered carry-out; held like sum
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = WIDTH / BPC;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_err
            $error("serial_adder: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, done_q, busy_q;

    // One slice of full adders: low BPC bits of each operand plus the running carry.
    logic [BPC:0]     slice_d;
    logic [WIDTH-1:0] part_d;
    logic [WIDTH-1:0] res_d;

    assign slice_d = {1'b0, a_sh_q[BPC-1:0]} + {1'b0, b_sh_q[BPC-1:0]}
                   + {{BPC{1'b0}}, carry_q};

    // The new partial sum enters at the MSB end. After N shifts, the first slice
    // produced has reached bit 0, so the register holds the result in order.
    // When N==1, the shift term is all zero and the partial sum is the full result.
    assign part_d = WIDTH'(slice_d[BPC-1:0]) << (WIDTH - BPC);
    assign res_d  = part_d | (res_sh_q >> BPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> BPC;
                    b_sh_q   <= b_sh_q >> BPC;
                    res_sh_q <= res_d;
                    carry_q  <= slice_d[BPC];
                    cnt_q    <= cnt_q + 1'b1;
                    // sum/cout change only here, so partial results are never visible.
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= slice_d[BPC];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
